// File: rtl/game_ctrl.sv
// game_ctrl: frame-synchronous game supervisor.
// Samples sprite collisions during a frame and tracks requests as they arrive.
// It changes state, score, speed and lives only on the vsync falling edge,
// so the display never changes partway through a frame.
module game_ctrl #(
  parameter int NUM_OBJ      = 2,
  parameter int SCORE_W      = 16,
  parameter int SPEED_W      = 4,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int SCORE_DIV    = 6,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = 15,
  parameter int SPEED_STEP   = 100
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               vs,
  input  logic               px_player,
  input  logic [NUM_OBJ-1:0] px_obstacle,
  output logic               game_status,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SPEED_W-1:0] speed,
  output logic [3:0]         lives,
  output logic               hit_pulse,
  output logic               over_pulse
);

  localparam int FW  = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
  localparam int STW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int GW  = $clog2(GRACE_FRAMES + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_HIT    = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;

  logic [2:0]         state_r, state_nxt_s;
  logic               vs_d_r, pause_d_r;
  logic               start_req_r, pause_req_r, hit_latch_r;
  logic               start_req_nxt_s, pause_req_nxt_s, hit_latch_nxt_s;
  logic [FW-1:0]      frame_r, frame_nxt_s, upd_frame_s;
  logic [STW-1:0]     step_r, step_nxt_s, upd_step_s;
  logic [GW-1:0]      grace_r, grace_nxt_s;
  logic [SCORE_W-1:0] score_r, score_nxt_s, upd_score_s;
  logic [SPEED_W-1:0] speed_r, speed_nxt_s, upd_speed_s;
  logic [3:0]         lives_r, lives_nxt_s;
  logic               hit_pulse_r, hit_pulse_nxt_s;
  logic               over_pulse_r, over_pulse_nxt_s;
  logic               game_status_r;
  logic               tick_s, pause_edge_s, collide_s, idle_or_over_s;

  assign tick_s         = vs_d_r & ~vs;
  assign pause_edge_s   = PAUSE & ~pause_d_r;
  assign collide_s      = px_player & (|px_obstacle);
  assign idle_or_over_s = (state_r == ST_IDLE) | (state_r == ST_OVER);

  assign game_status = game_status_r;
  assign state       = state_r;
  assign score       = score_r;
  assign speed       = speed_r;
  assign lives       = lives_r;
  assign hit_pulse   = hit_pulse_r;
  assign over_pulse  = over_pulse_r;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; moves happen only on a frame tick.
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start_req_r) state_nxt_s = ST_RUN;
          else             state_nxt_s = state_r;
        end
        ST_RUN: begin
          if (hit_latch_r) begin
            if (lives_r == 4'd1) state_nxt_s = ST_OVER;
            else                 state_nxt_s = ST_HIT;
          end else if (pause_req_r) begin
            state_nxt_s = ST_PAUSED;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HIT: begin
          if (grace_r == GW'(1)) state_nxt_s = ST_RUN;
          else                   state_nxt_s = ST_HIT;
        end
        ST_PAUSED: begin
          if (pause_req_r) state_nxt_s = ST_RUN;
          else             state_nxt_s = ST_PAUSED;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Candidate score/speed values for a frame that earns progress.
  always_comb begin
    upd_score_s = score_r;
    upd_speed_s = speed_r;
    upd_step_s  = step_r;
    if (frame_r == FW'(SCORE_DIV - 1)) begin
      upd_frame_s = {FW{1'b0}};
      if (score_r != {SCORE_W{1'b1}}) begin
        upd_score_s = score_r + 1'b1;
        if (step_r == STW'(SPEED_STEP - 1)) begin
          upd_step_s = {STW{1'b0}};
          if (speed_r != SPEED_W'(SPEED_MAX)) upd_speed_s = speed_r + 1'b1;
          else                                upd_speed_s = speed_r;
        end else begin
          upd_step_s = step_r + 1'b1;
        end
      end else begin
        upd_score_s = score_r;
      end
    end else begin
      upd_frame_s = frame_r + 1'b1;
    end
  end

  // Output/datapath next values: request capture, counters, lives, pulses.
  always_comb begin
    score_nxt_s      = score_r;
    speed_nxt_s      = speed_r;
    lives_nxt_s      = lives_r;
    frame_nxt_s      = frame_r;
    step_nxt_s       = step_r;
    grace_nxt_s      = grace_r;
    hit_pulse_nxt_s  = 1'b0;
    over_pulse_nxt_s = 1'b0;
    start_req_nxt_s  = start_req_r | (START & idle_or_over_s);
    // A pause request never survives into IDLE/OVER.
    if (idle_or_over_s) pause_req_nxt_s = 1'b0;
    else                pause_req_nxt_s = pause_req_r | pause_edge_s;
    // The collision latch is consumed by every tick.
    if (tick_s) hit_latch_nxt_s = 1'b0;
    else        hit_latch_nxt_s = hit_latch_r | (collide_s & (state_r == ST_RUN));
    if (tick_s) begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start_req_r) begin
            score_nxt_s     = {SCORE_W{1'b0}};
            speed_nxt_s     = SPEED_W'(SPEED_INIT);
            lives_nxt_s     = 4'(LIVES);
            frame_nxt_s     = {FW{1'b0}};
            step_nxt_s      = {STW{1'b0}};
            grace_nxt_s     = {GW{1'b0}};
            start_req_nxt_s = 1'b0;
          end else begin
            score_nxt_s = score_r;
          end
        end
        ST_RUN: begin
          if (hit_latch_r && (lives_r == 4'd1)) begin
            lives_nxt_s      = 4'd0;
            hit_pulse_nxt_s  = 1'b1;
            over_pulse_nxt_s = 1'b1;
          end else if (hit_latch_r) begin
            lives_nxt_s     = lives_r - 4'd1;
            grace_nxt_s     = GW'(GRACE_FRAMES);
            hit_pulse_nxt_s = 1'b1;
            frame_nxt_s     = upd_frame_s;
            score_nxt_s     = upd_score_s;
            step_nxt_s      = upd_step_s;
            speed_nxt_s     = upd_speed_s;
          end else if (pause_req_r) begin
            pause_req_nxt_s = 1'b0;
          end else begin
            frame_nxt_s = upd_frame_s;
            score_nxt_s = upd_score_s;
            step_nxt_s  = upd_step_s;
            speed_nxt_s = upd_speed_s;
          end
        end
        ST_HIT: begin
          grace_nxt_s = grace_r - 1'b1;
          frame_nxt_s = upd_frame_s;
          score_nxt_s = upd_score_s;
          step_nxt_s  = upd_step_s;
          speed_nxt_s = upd_speed_s;
        end
        ST_PAUSED: begin
          if (pause_req_r) pause_req_nxt_s = 1'b0;
          else             pause_req_nxt_s = pause_req_r | pause_edge_s;
        end
        default: begin
          score_nxt_s = score_r;
        end
      endcase
    end else begin
      score_nxt_s = score_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      vs_d_r        <= 1'b1;
      pause_d_r     <= 1'b0;
      start_req_r   <= 1'b0;
      pause_req_r   <= 1'b0;
      hit_latch_r   <= 1'b0;
      frame_r       <= {FW{1'b0}};
      step_r        <= {STW{1'b0}};
      grace_r       <= {GW{1'b0}};
      score_r       <= {SCORE_W{1'b0}};
      speed_r       <= SPEED_W'(SPEED_INIT);
      lives_r       <= 4'(LIVES);
      hit_pulse_r   <= 1'b0;
      over_pulse_r  <= 1'b0;
      game_status_r <= 1'b0;
    end else begin
      vs_d_r        <= vs;
      pause_d_r     <= PAUSE;
      start_req_r   <= start_req_nxt_s;
      pause_req_r   <= pause_req_nxt_s;
      hit_latch_r   <= hit_latch_nxt_s;
      frame_r       <= frame_nxt_s;
      step_r        <= step_nxt_s;
      grace_r       <= grace_nxt_s;
      score_r       <= score_nxt_s;
      speed_r       <= speed_nxt_s;
      lives_r       <= lives_nxt_s;
      hit_pulse_r   <= hit_pulse_nxt_s;
      over_pulse_r  <= over_pulse_nxt_s;
      game_status_r <= (state_nxt_s == ST_RUN) | (state_nxt_s == ST_HIT);
    end
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Parametrised successor to the top-level game_status/trigger_start logic: a frame-synchronous game supervisor FSM.
- Adds multi-obstacle collision, lives with post-hit invulnerability, pause, score counting and automatic speed ramp.
- Sits between the Vga timing (vs) and the Jump/Ground/Cactus sprite blocks. It drives their game_status and speed inputs and consumes their pixel-hit outputs.
- All game-state changes take effect only at frame boundaries, so the display never tears mid-frame.

Parameters:
NUM_OBJ, 2, number of obstacle pixel channels (px_obstacle width), >=1
SCORE_W, 16, score counter width
SPEED_W, 4, speed output width
LIVES, 3, lives at game start, 1..15
GRACE_FRAMES, 60, invulnerable frames after a non-fatal hit, >=1
SCORE_DIV, 6, frames per score point, >=1
SPEED_INIT, 1, speed at game start
SPEED_MAX, 15, speed saturation value, <2^SPEED_W
SPEED_STEP, 100, score points per speed increment, >=1

Ports:
CLK  in  1  system clock; all logic on posedge
RESET_N  in  1  synchronous active-low reset
START  in  1  start request, active-high level (already inverted from START_N)
PAUSE  in  1  pause toggle button, active-high level
vs  in  1  VGA vsync, active-low; falling edge marks the frame boundary
px_player  in  1  player sprite pixel at current scan position
px_obstacle  in  NUM_OBJ  obstacle sprite pixels at current scan position
game_status  out  1  1 in RUN or HIT state, else 0
state  out  3  IDLE=0, RUN=1, HIT=2, PAUSED=3, OVER=4
score  out  SCORE_W  current score
speed  out  SPEED_W  current speed level
lives  out  4  remaining lives
hit_pulse  out  1  one-CLK pulse when a collision is charged
over_pulse  out  1  one-CLK pulse on entering OVER

Behaviour:
- Reset: RESET_N sampled low at a CLK edge takes effect at that edge, in any state and mid-game.
  - state=IDLE, score=0, speed=SPEED_INIT, lives=LIVES.
  - hit_pulse=0, over_pulse=0.
  - Internal regs cleared: start_req, pause_req, hit_latch, frame/step/grace counters; vs_d=1.
- Frame tick: vs_d registers vs each cycle. tick = vs_d & ~vs, one CLK wide. All state transitions and counter updates happen only on tick.
- start_req: set when START=1 in IDLE or OVER. Ignored in RUN, HIT and PAUSED. Cleared when consumed.
- pause_req: set on a PAUSE rising edge, via an internal registered copy of PAUSE.
  - In IDLE/OVER the edge is discarded.
  - In HIT the request is held until the FSM returns to RUN.
  - Cleared when consumed.
- hit_latch: set on any cycle in RUN where px_player & |px_obstacle. Cleared on every tick after evaluation. Not set in HIT (invulnerable), PAUSED, IDLE or OVER.
- IDLE/OVER, on tick with start_req set: go to RUN.
  - score=0, speed=SPEED_INIT, lives=LIVES, counters=0.
  - Clear start_req and hit_latch.
  - OVER otherwise holds all values frozen.
- RUN, on tick, in priority order:
  - (a) hit_latch set and lives==1: lives=0, go to OVER, over_pulse=1 and hit_pulse=1 that cycle. No score update.
  - (b) hit_latch set and lives>1: lives-1, grace=GRACE_FRAMES, go to HIT, hit_pulse=1. Score update applies.
  - (c) pause_req set: go to PAUSED, clear pause_req. No score update.
  - (d) otherwise stay in RUN. Score update applies.
- HIT, on tick: grace decrements. When grace==1 before decrement, go to RUN. Score update applies.
- PAUSED, on tick with pause_req set: go to RUN, clear pause_req. All counters frozen while PAUSED.
- Score update, when it applies:
  - frame_cnt increments.
  - At frame_cnt==SCORE_DIV-1 it wraps to 0 and score increments, saturating at all-ones.
  - Each score increment advances step_cnt. At step_cnt==SPEED_STEP-1 it wraps to 0 and speed increments, saturating at SPEED_MAX.
- Pulses: hit_pulse and over_pulse are asserted only in the tick cycle, registered and 0 otherwise.
- Simultaneous events:
  - RESET_N low overrides everything.
  - A collision beats a pause in the same frame: the request is held and taken on the next RUN tick.
  - START in the same cycle as the tick that enters OVER is ignored, because start_req is only settable in OVER.
- game_status is a registered decode of state, with no extra latency beyond state.

Test Plan:
- Bench params: LIVES=2, GRACE_FRAMES=2, SCORE_DIV=2, SPEED_STEP=3, SPEED_INIT=1, SPEED_MAX=2, NUM_OBJ=2.
- Reset, pulse START, then one vs falling edge -> state 0→1 exactly at the tick cycle, game_status=1, lives=2, score=0, speed=1.
- Run 12 frames with no overlap -> score=6, speed=2 after score 3, and speed stays 2 at score 6 (saturated).
- Overlap px_player & px_obstacle[1] for one pixel in RUN, then tick:
  - hit_pulse for 1 cycle, lives=1, state=2.
  - Overlaps during the next 2 frames are ignored.
  - state returns to 1 on the 2nd tick.
- Overlap again in RUN, then tick -> hit_pulse=1 and over_pulse=1 same cycle, state=4, lives=0, score frozen. START then tick -> state=1, score=0, lives=2.
- PAUSE edge mid-frame in RUN -> state=3 at next tick. 5 frames pass with score unchanged. PAUSE edge -> state=1 at next tick.
- Drive RESET_N=0 for one cycle while in HIT -> next edge state=0, score=0, lives=2, speed=1, no pulses.
